seq_burst_collector: RTL and testbench

Downstream consumer of the ring-cipher sequencer's output burst. It captures one contiguous `out_valid` burst (circle indices on the first three beats, a value on every beat) and reduces it to a single result record: pins, sum, min, max, sortedness and length. The record is presented on a valid/ready port. The sequencer has no backpressure, so bursts arriving while a record is unconsumed are dropped and counted.

---
 rtl/seq_burst_collector_if.sv | 36 +++
 rtl/seq_burst_collector.sv | 173 +++++++++++++++++
 tb/tb_seq_burst_collector.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seq_burst_collector_if.sv
// Burst-in / record-out bundle for seq_burst_collector.
// master = sequencer plus record consumer, slave = collector.
interface seq_burst_collector_if #(
  parameter int VAL_W = 8
);
  localparam int SUM_W = VAL_W + 3;

  logic             s_valid;
  logic [2:0]       s_circle;
  logic [VAL_W-1:0] s_value;
  logic             res_valid;
  logic             res_ready;
  logic [2:0]       res_pin0;
  logic [2:0]       res_pin1;
  logic [2:0]       res_pin2;
  logic [SUM_W-1:0] res_sum;
  logic [VAL_W-1:0] res_min;
  logic [VAL_W-1:0] res_max;
  logic             res_sorted;
  logic [3:0]       res_len;
  logic             res_ovf;
  logic             res_short;
  logic [7:0]       drop_cnt;

  modport master (
    output s_valid, s_circle, s_value, res_ready,
    input  res_valid, res_pin0, res_pin1, res_pin2, res_sum, res_min, res_max,
           res_sorted, res_len, res_ovf, res_short, drop_cnt
  );

  modport slave (
    input  s_valid, s_circle, s_value, res_ready,
    output res_valid, res_pin0, res_pin1, res_pin2, res_sum, res_min, res_max,
           res_sorted, res_len, res_ovf, res_short, drop_cnt
  );
endinterface

// File: rtl/seq_burst_collector.sv
// Reduces one sequencer output burst to a result record held on a valid/ready port.
// Define SEQ_COLLECT_SORTCHK_EN to build the sortedness checker; otherwise res_sorted is 1.
module seq_burst_collector #(
  parameter int BURST_MAX = 8,
  parameter int VAL_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_burst_collector_if.slave bus
);
  localparam int         SUM_W   = VAL_W + 3;
  localparam logic [3:0] LP_BMAX = 4'(BURST_MAX);

  typedef enum logic [1:0] {
    ST_SKIP    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_accum;
  logic             w_ovf_set;
  logic             w_drop_first;
  logic             w_flag_nxt;

  logic             r_res_valid;
  logic             r_drop_flag;
  logic [7:0]       r_drop_cnt;
  logic [2:0]       r_pin0;
  logic [2:0]       r_pin1;
  logic [2:0]       r_pin2;
  logic [SUM_W-1:0] r_sum;
  logic [VAL_W-1:0] r_min;
  logic [VAL_W-1:0] r_max;
  logic [3:0]       r_len;
  logic             r_ovf;
  logic             r_short;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_SKIP;
    else     r_state <= w_state_nxt;
  end

  // r_drop_flag marks a dropped burst still running, so its tail is never collected.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_accum      = 1'b0;
    w_ovf_set    = 1'b0;
    w_drop_first = 1'b0;
    w_flag_nxt   = r_drop_flag;
    case (r_state)
      ST_SKIP: begin
        if (!bus.s_valid) w_state_nxt = ST_IDLE;
        else              w_state_nxt = ST_SKIP;
      end
      ST_IDLE: begin
        if (bus.s_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (bus.s_valid) begin
          if (r_len < LP_BMAX) w_accum   = 1'b1;
          else                 w_ovf_set = 1'b1;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          w_flag_nxt = 1'b0;
          if (!bus.s_valid) begin
            w_state_nxt = ST_IDLE;
          end else if (r_drop_flag) begin
            w_state_nxt = ST_SKIP;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_COLLECT;
          end
        end else if (bus.s_valid) begin
          w_drop_first = !r_drop_flag;
          w_flag_nxt   = 1'b1;
        end else begin
          w_flag_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_SKIP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_drop_flag <= 1'b0;
      r_drop_cnt  <= 8'd0;
      r_pin0      <= 3'd0;
      r_pin1      <= 3'd0;
      r_pin2      <= 3'd0;
      r_sum       <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_len       <= 4'd0;
      r_ovf       <= 1'b0;
      r_short     <= 1'b0;
    end else begin
      r_res_valid <= (w_state_nxt == ST_HOLD);
      r_drop_flag <= w_flag_nxt;
      if (w_drop_first && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_load) begin
        r_pin0  <= bus.s_circle;
        r_pin1  <= 3'd0;
        r_pin2  <= 3'd0;
        r_sum   <= {{3{1'b0}}, bus.s_value};
        r_min   <= bus.s_value;
        r_max   <= bus.s_value;
        r_len   <= 4'd1;
        r_ovf   <= 1'b0;
        r_short <= 1'b1;
      end else if (w_accum) begin
        if (r_len == 4'd1) r_pin1 <= bus.s_circle;
        if (r_len == 4'd2) r_pin2 <= bus.s_circle;
        r_sum   <= r_sum + {{3{1'b0}}, bus.s_value};
        if (bus.s_value < r_min) r_min <= bus.s_value;
        if (bus.s_value > r_max) r_max <= bus.s_value;
        r_len   <= r_len + 4'd1;
        r_short <= (r_len < 4'd2);
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef SEQ_COLLECT_SORTCHK_EN
  logic [VAL_W-1:0] r_prev;
  logic             r_sorted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev   <= '0;
      r_sorted <= 1'b0;
    end else if (w_load) begin
      r_prev   <= bus.s_value;
      r_sorted <= 1'b1;
    end else if (w_accum) begin
      r_prev <= bus.s_value;
      if (bus.s_value < r_prev) r_sorted <= 1'b0;
    end
  end

  assign bus.res_sorted = r_sorted;
`else
  assign bus.res_sorted = 1'b1;
`endif

  assign bus.res_valid = r_res_valid;
  assign bus.res_pin0  = r_pin0;
  assign bus.res_pin1  = r_pin1;
  assign bus.res_pin2  = r_pin2;
  assign bus.res_sum   = r_sum;
  assign bus.res_min   = r_min;
  assign bus.res_max   = r_max;
  assign bus.res_len   = r_len;
  assign bus.res_ovf   = r_ovf;
  assign bus.res_short = r_short;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_seq_burst_collector.sv
// Directed bench for seq_burst_collector: nominal, overflow, short, drop,
// simultaneous release and mid-burst reset, with hand-computed records.
module tb_seq_burst_collector;
`ifdef SEQ_COLLECT_SORTCHK_EN
  localparam int SORTCHK = 1;
`else
  localparam int SORTCHK = 0;
`endif
  // Expected res_sorted for a non-monotonic burst, and out of reset.
  localparam int UNSORTED = (SORTCHK != 0) ? 0 : 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   bc[$];
  int   bv[$];

  seq_burst_collector_if #(.VAL_W(8)) bus ();

  seq_burst_collector #(.BURST_MAX(8), .VAL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_valid"}, 32'(bus.res_valid), 0);
    chk({t, "_pin0"},  32'(bus.res_pin0), 0);
    chk({t, "_sum"},   32'(bus.res_sum), 0);
    chk({t, "_max"},   32'(bus.res_max), 0);
    chk({t, "_len"},   32'(bus.res_len), 0);
    chk({t, "_sort"},  32'(bus.res_sorted), UNSORTED);
    chk({t, "_short"}, 32'(bus.res_short), 0);
    chk({t, "_drop"},  32'(bus.drop_cnt), 0);
  endtask

  task automatic chk_rec(input string t, input int p0, input int p1, input int p2,
                         input int sum, input int mn, input int mx, input int srt,
                         input int len, input int ovf, input int sh);
    chk({t, "_valid"}, 32'(bus.res_valid), 1);
    chk({t, "_pin0"},  32'(bus.res_pin0), p0);
    chk({t, "_pin1"},  32'(bus.res_pin1), p1);
    chk({t, "_pin2"},  32'(bus.res_pin2), p2);
    chk({t, "_sum"},   32'(bus.res_sum), sum);
    chk({t, "_min"},   32'(bus.res_min), mn);
    chk({t, "_max"},   32'(bus.res_max), mx);
    chk({t, "_sort"},  32'(bus.res_sorted), srt);
    chk({t, "_len"},   32'(bus.res_len), len);
    chk({t, "_ovf"},   32'(bus.res_ovf), ovf);
    chk({t, "_short"}, 32'(bus.res_short), sh);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
    end
  endtask

  // One beat per negedge from bc/bv; optional ready-on-first-beat and reset-at-beat.
  task automatic send(input bit rdy_first, input int rst_at);
    for (int i = 0; i < bv.size(); i++) begin
      @(negedge clk);
      if (rdy_first && i == 1) chk("c_released", 32'(bus.res_valid), 0);
      if (rst_at >= 0 && i == rst_at + 1) chk_zero("rst");
      rst          = (i == rst_at);
      bus.s_valid  = 1'b1;
      bus.s_circle = 3'(bc[i]);
      bus.s_value  = 8'(bv[i]);
      if (rdy_first && i == 0) bus.res_ready = 1'b1;
    end
  endtask

  // End the burst and land on the first cycle the record should be visible.
  task automatic close(input string t);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk({t, "_lat"}, 32'(bus.res_valid), 0);
    @(negedge clk);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_circle  = 3'd0;
    bus.s_value   = 8'd0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    idle(2);

    // Nominal burst, ready held high.
    bus.res_ready = 1'b1;
    bc = '{3, 5, 1, 0, 0, 0, 0};
    bv = '{10, 20, 30, 40, 50, 60, 70};
    send(1'b0, -1);
    close("nom");
    chk_rec("nom", 3, 5, 1, 280, 10, 70, 1, 7, 0, 0);
    idle(1);
    chk("nom_released", 32'(bus.res_valid), 0);

    // Descending 10 beats: first 8 accepted, then overflow.
    bc = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    bv = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    send(1'b0, -1);
    close("ovf");
    chk_rec("ovf", 0, 1, 2, 44, 2, 9, UNSORTED, 8, 1, 0);
    idle(1);

    // Two-beat burst.
    bc = '{6, 2};
    bv = '{255, 255};
    send(1'b0, -1);
    close("short");
    chk_rec("short", 6, 2, 0, 510, 255, 255, 1, 2, 0, 1);
    idle(1);

    // Burst A held unconsumed; burst B must be dropped.
    bus.res_ready = 1'b0;
    bc = '{1, 2, 3};
    bv = '{1, 1, 1};
    send(1'b0, -1);
    close("a");
    chk_rec("a", 1, 2, 3, 3, 1, 1, 1, 3, 0, 0);
    idle(2);
    chk("a_hold", 32'(bus.res_valid), 1);
    bc = '{7, 7, 7};
    bv = '{5, 5, 5};
    send(1'b0, -1);
    idle(2);
    chk("b_drop_cnt", 32'(bus.drop_cnt), 1);
    chk("b_valid", 32'(bus.res_valid), 1);
    chk("b_keep_sum", 32'(bus.res_sum), 3);
    chk("b_keep_len", 32'(bus.res_len), 3);

    // Ready rises with the first beat of C: A released, C collected.
    bc = '{4, 5, 6};
    bv = '{4, 4, 4};
    send(1'b1, -1);
    close("c");
    chk_rec("c", 4, 5, 6, 12, 4, 4, 1, 3, 0, 0);
    chk("c_drop_cnt", 32'(bus.drop_cnt), 1);
    idle(1);

    // Reset on beat 3 of 7: record lost, tail ignored, drop count cleared.
    bc = '{1, 2, 3, 4, 5, 6, 7};
    bv = '{11, 12, 13, 14, 15, 16, 17};
    send(1'b0, 2);
    idle(1);
    chk("rst_no_rec1", 32'(bus.res_valid), 0);
    idle(2);
    chk("rst_no_rec2", 32'(bus.res_valid), 0);
    chk("rst_len", 32'(bus.res_len), 0);

    // Recovery burst after reset.
    bc = '{7, 6, 5, 4, 3};
    bv = '{3, 1, 4, 1, 5};
    send(1'b0, -1);
    close("rec");
    chk_rec("rec", 7, 6, 5, 14, 1, 5, UNSORTED, 5, 0, 0);
    chk("rec_drop_cnt", 32'(bus.drop_cnt), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
